pixel_write_sink: RTL and testbench

- Receiving end of the pixel-plot stream that movement and sprite datapaths produce as plot/x/y/colour strobes.
- Buffers each plot request in a small FIFO and clips off-screen coordinates.
- Converts each accepted request to a linear framebuffer address and issues it on a single-beat write port with a ready handshake.
- Also performs whole-screen fills on request, such as clearing the playfield between rounds.

---
 rtl/pixel_pkg.sv | 35 +++
 rtl/pixel_fifo.sv | 77 +++++++
 rtl/pixel_write_sink.sv | 198 +++++++++++++++++++
 tb/tb_pixel_write_sink.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// -----------------------------------------------------------------------------
// pixel_pkg
// Shared definitions for the pixel write sink: default screen geometry and
// framebuffer address width, named colours, the sink FSM state type and the
// linear framebuffer address helper.
// -----------------------------------------------------------------------------
package pixel_pkg;

    // Default playfield geometry; 160*120 = 19200 fits in a 15-bit address.
    localparam int DEFAULT_SCREEN_W = 160;
    localparam int DEFAULT_SCREEN_H = 120;
    localparam int DEFAULT_ADDR_W   = 15;

    // 3-bit RGB colours used by the game datapaths.
    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;

    // IDLE  : normal plot path
    // DRAIN : fill requested, flushing queued plots
    // FILL  : sweeping every framebuffer address with the fill colour
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FILL  = 2'd2
    } sink_state_t;

    // Row-major linear address y*screen_w + x, returned at full 32-bit width
    // so the caller truncates to whatever framebuffer width it uses.
    function automatic logic [31:0] pixel_addr(input logic [7:0] x,
                                               input logic [6:0] y,
                                               input int         screen_w);
        return (32'(y) * 32'(screen_w)) + 32'(x);
    endfunction

endpackage : pixel_pkg

// File: rtl/pixel_fifo.sv
// -----------------------------------------------------------------------------
// pixel_fifo
// Synchronous FIFO holding queued plot requests ({addr, colour}).
// Head data is presented combinationally (first-word fall-through) so the
// output stage can load it in the same cycle it pops.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset (empties the FIFO)
//   push       write push_data into the tail (ignored when full)
//   push_data  entry to store
//   pop        discard the head entry (ignored when empty)
//   head       current head entry, valid when !empty
//   full       DEPTH entries stored
//   empty      no entries stored
//   count      occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module pixel_fifo
    import pixel_pkg::*;
#(
    parameter int WIDTH = DEFAULT_ADDR_W + 3,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // NOTE: registers are written with non-blocking assignments so every
    // flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally on overflow.
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;   // idle, or push and pop together
            endcase
        end
    end

    // NOTE: the storage array has no reset; the pointers/count define which
    // entries are valid, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule : pixel_fifo

// File: rtl/pixel_write_sink.sv
// -----------------------------------------------------------------------------
// pixel_write_sink
// Receiving end of the plot/x/y/colour pixel stream. Each accepted plot is
// clipped against the screen, converted to a linear framebuffer address,
// queued, and issued on a single-beat write port with a ready handshake.
// A fill request flushes the queue and then writes the fill colour to every
// framebuffer address.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   plot         one-cycle plot strobe; x, y, colour sampled while high
//   x, y         pixel column / row
//   colour       3-bit RGB pixel value
//   busy         FIFO full or fill pending/active; plots dropped while high
//   fill_req     one-cycle whole-screen fill request (honoured in IDLE only)
//   fill_colour  fill colour, sampled with fill_req
//   fill_done    one-cycle pulse after the last fill write is accepted
//   mem_addr     framebuffer write address
//   mem_data     framebuffer write data
//   mem_we       write valid
//   mem_ready    write accepted when mem_we && mem_ready
//   overflow     sticky: a plot arrived while busy
//   clipped      sticky: a plot arrived with off-screen coordinates
// -----------------------------------------------------------------------------
module pixel_write_sink
    import pixel_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int SCREEN_W   = DEFAULT_SCREEN_W,
    parameter int SCREEN_H   = DEFAULT_SCREEN_H,
    parameter int ADDR_W     = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              plot,
    input  logic [7:0]        x,
    input  logic [6:0]        y,
    input  logic [2:0]        colour,
    output logic              busy,
    input  logic              fill_req,
    input  logic [2:0]        fill_colour,
    output logic              fill_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_data,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic              overflow,
    output logic              clipped
);

    localparam int ENTRY_W = ADDR_W + 3;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

    sink_state_t        state;
    sink_state_t        state_next;

    logic               in_range;
    logic [ADDR_W-1:0]  plot_addr;
    logic               push;
    logic               pop;
    logic               transfer;
    logic               start_fill;
    logic               fill_last;

    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_head;

    logic [2:0]         fill_colour_q;
    logic [ADDR_W-1:0]  fill_cnt;

    // ---------------------------------------------------------------------
    // Input side: clipping, address generation, enqueue
    // ---------------------------------------------------------------------
    // busy is built only from registered state, so a pop in the current
    // cycle never lets a plot slip into a full FIFO.
    assign busy = fifo_full || (state != IDLE);

    assign in_range  = (32'(x) < SCREEN_W) && (32'(y) < SCREEN_H);
    assign plot_addr = ADDR_W'(pixel_addr(x, y, SCREEN_W));
    assign push      = plot && !busy && in_range;

    // ---------------------------------------------------------------------
    // Output stage handshake
    // ---------------------------------------------------------------------
    assign transfer = mem_we && mem_ready;

    // Reload from the queue when the stage is empty or being emptied this
    // cycle; the fill sweep owns the stage while in FILL.
    assign pop = (state != FILL) && !fifo_empty && (!mem_we || transfer);

    pixel_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({plot_addr, colour}),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        start_fill = 1'b0;
        fill_last  = 1'b0;
        unique case (state)
            IDLE: begin
                if (fill_req) state_next = DRAIN;
            end
            DRAIN: begin
                // Queue empty and no write outstanding: the sweep may take
                // over the output stage.
                if ((fifo_count == '0) && !mem_we) begin
                    state_next = FILL;
                    start_fill = 1'b1;
                end
            end
            FILL: begin
                if (transfer && (fill_cnt == LAST_ADDR)) begin
                    state_next = IDLE;
                    fill_last  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Fill colour capture and sticky status flags
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_colour_q <= BLACK;
            overflow      <= 1'b0;
            clipped       <= 1'b0;
        end else begin
            if ((state == IDLE) && fill_req) fill_colour_q <= fill_colour;
            if (plot && busy)                overflow <= 1'b1;
            if (plot && !busy && !in_range)  clipped  <= 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Registered write port
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= BLACK;
            fill_cnt  <= '0;
            fill_done <= 1'b0;
        end else begin
            fill_done <= fill_last;
            if (start_fill) begin
                mem_we   <= 1'b1;
                mem_addr <= '0;
                mem_data <= fill_colour_q;
                fill_cnt <= '0;
            end else if (state == FILL) begin
                if (transfer) begin
                    if (fill_last) begin
                        mem_we <= 1'b0;
                    end else begin
                        fill_cnt <= fill_cnt + ADDR_W'(1);
                        mem_addr <= fill_cnt + ADDR_W'(1);
                    end
                end
            end else if (pop) begin
                mem_we   <= 1'b1;
                mem_addr <= fifo_head[ENTRY_W-1:3];
                mem_data <= fifo_head[2:0];
            end else if (transfer) begin
                mem_we <= 1'b0;
            end
            // Otherwise a stalled write holds address and data stable.
        end
    end

endmodule : pixel_write_sink

// File: tb/tb_pixel_write_sink.sv
// -----------------------------------------------------------------------------
// tb_pixel_write_sink
// Directed bench for pixel_write_sink with hand-computed expected addresses.
// A negedge monitor logs every accepted write, fill_done pulses and busy
// cycles; the stimulus thread compares them against expected values.
// -----------------------------------------------------------------------------
module tb_pixel_write_sink;
    import pixel_pkg::*;

    logic        clk;
    logic        reset;
    logic        plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        busy;
    logic        fill_req;
    logic [2:0]  fill_colour;
    logic        fill_done;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        mem_ready;
    logic        overflow;
    logic        clipped;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t wr_q[$];
    int  cyc      = 0;
    int  fd_cnt   = 0;
    int  fd_cyc   = 0;
    int  busy_cnt = 0;
    int  checks   = 0;
    int  errors   = 0;

    pixel_write_sink #(
        .FIFO_DEPTH (8),
        .SCREEN_W   (160),
        .SCREEN_H   (120),
        .ADDR_W     (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .plot        (plot),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .busy        (busy),
        .fill_req    (fill_req),
        .fill_colour (fill_colour),
        .fill_done   (fill_done),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_we      (mem_we),
        .mem_ready   (mem_ready),
        .overflow    (overflow),
        .clipped     (clipped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after posedge, so values seen here are the ones the
    // next posedge will act on.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mem_we === 1'b1 && mem_ready === 1'b1)
            wr_q.push_back('{int'(mem_addr), int'(mem_data), cyc});
        if (fill_done === 1'b1) begin
            fd_cnt <= fd_cnt + 1;
            fd_cyc <= cyc;
        end
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        plot     = 1'b0;
        fill_req = 1'b0;
        reset    = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One-cycle plot; returns 1 ns after the edge that sampled it.
    task automatic send(input int px, input int py, input int pc);
        x      = 8'(px);
        y      = 7'(py);
        colour = 3'(pc);
        plot   = 1'b1;
        tick();
        plot = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int bbase;
        int fbase;
        int bad;
        int n;
        int exp_addr [4];
        int exp_data [4];

        reset = 1'b1; plot = 1'b0; x = '0; y = '0; colour = '0;
        fill_req = 1'b0; fill_colour = '0; mem_ready = 1'b0;
        do_reset();

        // ---- reset state ----
        check("rst_we",        mem_we,    0);
        check("rst_addr",      mem_addr,  0);
        check("rst_data",      mem_data,  0);
        check("rst_busy",      busy,      0);
        check("rst_overflow",  overflow,  0);
        check("rst_clipped",   clipped,   0);
        check("rst_fill_done", fill_done, 0);

        // ---- single plot (50,50) red: 50*160+50 = 8050 ----
        mem_ready = 1'b1;
        base = wr_q.size();
        send(50, 50, 4);
        check("single_we_e0", mem_we, 0);
        tick();
        check("single_we_e1", mem_we,   1);
        check("single_addr",  mem_addr, 8050);
        check("single_data",  mem_data, 4);
        tick();
        check("single_we_e2", mem_we, 0);
        check("single_count", wr_q.size() - base, 1);

        // ---- 4-pixel sprite burst on row 20: 3200 + x ----
        exp_addr = '{3210, 3211, 3212, 3213};
        exp_data = '{1, 2, 3, 5};
        base  = wr_q.size();
        bbase = busy_cnt;
        for (int i = 0; i < 4; i++) send(10 + i, 20, exp_data[i]);
        repeat (4) tick();
        check("burst_count", wr_q.size() - base, 4);
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (wr_q.size() > base + i)
                if (wr_q[base+i].addr != exp_addr[i] || wr_q[base+i].data != exp_data[i]) bad++;
        check("burst_order", bad, 0);
        if (wr_q.size() >= base + 4)
            check("burst_back_to_back", wr_q[base+3].cyc - wr_q[base].cyc, 3);
        check("burst_busy_cycles", busy_cnt - bbase, 0);

        // ---- backpressure: 10 plots on row 1 (addr 160+i, colour i+1) ----
        // Output stage holds one and the FIFO eight; the 10th is dropped.
        mem_ready = 1'b0;
        base = wr_q.size();
        for (int i = 0; i < 10; i++) send(i, 1, (i + 1) % 8);
        check("ovf_busy",     busy,     1);
        check("ovf_flag",     overflow, 1);
        check("ovf_we_stall", mem_we,   1);
        repeat (3) tick();
        check("ovf_hold_addr", mem_addr, 160);
        check("ovf_hold_data", mem_data, 1);
        check("ovf_no_writes", wr_q.size() - base, 0);
        mem_ready = 1'b1;
        repeat (14) tick();
        check("ovf_written", wr_q.size() - base, 9);
        bad = 0;
        for (int i = 0; i < 9; i++)
            if (wr_q.size() > base + i)
                if (wr_q[base+i].addr != 160 + i || wr_q[base+i].data != (i + 1) % 8) bad++;
        check("ovf_order", bad, 0);
        check("ovf_busy_after", busy, 0);

        // ---- clipping boundaries ----
        do_reset();
        base = wr_q.size();
        send(160, 0, 1);
        check("clip_x_flag", clipped,  1);
        check("clip_x_ovf",  overflow, 0);
        do_reset();
        check("clip_reset_clears", clipped, 0);
        send(0, 120, 2);
        check("clip_y_flag", clipped, 1);
        repeat (3) tick();
        check("clip_no_writes", wr_q.size() - base, 0);
        do_reset();
        send(159, 119, 6);
        repeat (3) tick();
        check("corner_clipped", clipped, 0);
        check("corner_count", wr_q.size() - base, 1);
        if (wr_q.size() > base) begin
            check("corner_addr", wr_q[base].addr, 19199);
            check("corner_data", wr_q[base].data, 6);
        end

        // ---- fill with BLACK behind 3 queued plots ----
        do_reset();
        mem_ready = 1'b0;
        base  = wr_q.size();
        fbase = fd_cnt;
        send(1, 0, 1);
        send(2, 0, 2);
        send(3, 0, 3);
        fill_req    = 1'b1;
        fill_colour = BLACK;
        tick();
        fill_req = 1'b0;
        check("fill_busy", busy, 1);
        send(5, 5, 7);
        check("fill_plot_overflow", overflow, 1);
        mem_ready = 1'b1;
        n = 0;
        while (fd_cnt == fbase && n < 25000) begin
            tick();
            n++;
        end
        tick();
        tick();
        check("fill_done_pulses", fd_cnt - fbase, 1);
        check("fill_write_count", wr_q.size() - base, 3 + 19200);
        bad = 0;
        for (int i = 0; i < 3; i++)
            if (wr_q.size() > base + i)
                if (wr_q[base+i].addr != i + 1 || wr_q[base+i].data != i + 1) bad++;
        check("fill_plots_first", bad, 0);
        bad = 0;
        for (int a = 0; a < 19200; a++)
            if (wr_q.size() > base + 3 + a)
                if (wr_q[base+3+a].addr != a || wr_q[base+3+a].data != 0) bad++;
        check("fill_sweep", bad, 0);
        if (wr_q.size() > 0)
            check("fill_done_timing", fd_cyc - wr_q[wr_q.size()-1].cyc, 1);
        check("fill_busy_after", busy, 0);
        check("fill_we_after",   mem_we, 0);

        // ---- reset in the middle of a RED fill with mem_ready toggling ----
        do_reset();
        base  = wr_q.size();
        fbase = fd_cnt;
        fill_req    = 1'b1;
        fill_colour = RED;
        tick();
        fill_req = 1'b0;
        for (int i = 0; i < 30; i++) begin
            mem_ready = (i % 2 == 1);
            tick();
        end
        check("midfill_we",   mem_we,   1);
        check("midfill_data", mem_data, 4);
        check("midfill_busy", busy,     1);
        if (wr_q.size() > base) begin
            check("midfill_first_addr", wr_q[base].addr, 0);
            check("midfill_first_data", wr_q[base].data, 4);
        end
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_rst_we",   mem_we,    0);
        check("async_rst_busy", busy,      0);
        check("async_rst_addr", mem_addr,  0);
        check("async_rst_done", fill_done, 0);
        tick();
        reset     = 1'b0;
        mem_ready = 1'b1;
        repeat (5) tick();
        check("midfill_no_done", fd_cnt - fbase, 0);
        base = wr_q.size();
        send(7, 3, 2);
        repeat (3) tick();
        check("post_rst_count", wr_q.size() - base, 1);
        if (wr_q.size() > base) begin
            check("post_rst_addr", wr_q[base].addr, 487);
            check("post_rst_data", wr_q[base].data, 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pixel_write_sink
